avmm_mem_responder: RTL and testbench



---
 rtl/avmm_pkg.sv | 30 +++
 rtl/avmm_read_pipe.sv | 46 ++++
 rtl/avmm_mem_responder.sv | 117 +++++++++++
 tb/tb_avmm_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package avmm_pkg;

  localparam int unsigned AVMM_DATA_W = 32;
  localparam int unsigned AVMM_BE_W   = 4;

  typedef struct packed {
    logic                   valid;
    logic [AVMM_DATA_W-1:0] data;
  } avmm_rsp_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_RW_BOTH = 2'd2;

  // Replace only the byte lanes selected by be.
  function automatic logic [AVMM_DATA_W-1:0] merge_bytes(
    input logic [AVMM_DATA_W-1:0] old_word,
    input logic [AVMM_DATA_W-1:0] new_word,
    input logic [AVMM_BE_W-1:0]   be
  );
    logic [AVMM_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(AVMM_BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avmm_read_pipe.sv
// Fixed-latency read return pipe; the last stage holds its data between returns.
module avmm_read_pipe
  import avmm_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  avmm_rsp_t in_rsp,
  output avmm_rsp_t tail,
  output logic      returning_c
);

  avmm_rsp_t stage [READ_LATENCY];
  avmm_rsp_t feed  [READ_LATENCY];

  always_comb begin
    feed[0] = in_rsp;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      feed[i] = stage[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        stage[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        if (i == int'(READ_LATENCY) - 1) begin
          stage[i].valid <= feed[i].valid;
          if (feed[i].valid) stage[i].data <= feed[i].data;
        end else begin
          stage[i] <= feed[i];
        end
      end
    end
  end

  // Pulses in the cycle before the entry appears on the output, so the
  // pending slot is already free while the data is being returned.
  assign returning_c = feed[READ_LATENCY-1].valid;
  assign tail        = stage[READ_LATENCY-1];

endmodule

// File: rtl/avmm_mem_responder.sv
// Avalon-MM pipelined memory responder with fixed read latency and bounded reads in flight.
module avmm_mem_responder
  import avmm_pkg::*;
#(
  parameter int unsigned ADDR_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            s_address,
  input  logic                   s_read,
  input  logic                   s_write,
  input  logic [AVMM_DATA_W-1:0] s_writedata,
  input  logic [AVMM_BE_W-1:0]   s_byteenable,
  output logic                   s_waitrequest,
  output logic [AVMM_DATA_W-1:0] s_readdata,
  output logic                   s_readdatavalid,
  input  logic                   force_wait,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int unsigned IDX_W  = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  logic [AVMM_DATA_W-1:0] mem [ADDR_WORDS];

  logic [31:0]            byte_off;
  logic [31:0]            word_off;
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic                   acc;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [1:0]             err_cause;
  logic [AVMM_DATA_W-1:0] rd_word;
  logic [PEND_W-1:0]      pending;
  avmm_rsp_t              pipe_in;
  avmm_rsp_t              pipe_tail;
  logic                   returning_c;

  // Address decode: no wrap-around below the base or past the last word.
  always_comb begin
    byte_off = s_address - BASE_ADDR;
    word_off = byte_off >> 2;
    idx      = word_off[IDX_W-1:0];
    in_range = (s_address >= BASE_ADDR) && (word_off < 32'(ADDR_WORDS));
  end

  assign s_waitrequest = force_wait | (pending == PEND_W'(MAX_PENDING));

  // A simultaneous read+write is treated as a write only.
  always_comb begin
    acc    = (s_read | s_write) & ~s_waitrequest;
    wr_acc = acc & s_write;
    rd_acc = acc & s_read & ~s_write;
  end

  always_comb begin
    err_cause = ERR_NONE;
    if (acc) begin
      if (s_read && s_write) err_cause = ERR_RW_BOTH;
      else if (!in_range)    err_cause = ERR_RANGE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      mem[idx] <= merge_bytes(mem[idx], s_writedata, s_byteenable);
    end
  end

  always_comb begin
    rd_word       = in_range ? mem[idx] : '0;
    pipe_in.valid = rd_acc;
    pipe_in.data  = rd_word;
  end

  avmm_read_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_rsp      (pipe_in),
    .tail        (pipe_tail),
    .returning_c (returning_c)
  );

  assign s_readdata      = pipe_tail.data;
  assign s_readdatavalid = pipe_tail.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      case ({rd_acc, returning_c})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   if (pending != '0) pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Sticky error; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_cause != ERR_NONE) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Directed bench: dut1 uses default latency, dut2 uses READ_LATENCY=6, MAX_PENDING=4.
module tb_avmm_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd, wr, sel;
  logic        force_wait, err_clr;

  logic        wr1, rv1, err1;
  logic [31:0] rdata1;
  logic        wr2, rv2, err2;
  logic [31:0] rdata2;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] q1d[$], q2d[$];
  int          q1c[$], q2c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avmm_mem_responder dut1 (
    .clk (clk), .rst_n (rst_n),
    .s_address (addr), .s_read (rd & ~sel), .s_write (wr & ~sel),
    .s_writedata (wdata), .s_byteenable (be),
    .s_waitrequest (wr1), .s_readdata (rdata1), .s_readdatavalid (rv1),
    .force_wait (force_wait), .err (err1), .err_clr (err_clr)
  );

  avmm_mem_responder #(.READ_LATENCY(6), .MAX_PENDING(4)) dut2 (
    .clk (clk), .rst_n (rst_n),
    .s_address (addr), .s_read (rd & sel), .s_write (wr & sel),
    .s_writedata (wdata), .s_byteenable (be),
    .s_waitrequest (wr2), .s_readdata (rdata2), .s_readdatavalid (rv2),
    .force_wait (force_wait), .err (err2), .err_clr (err_clr)
  );

  always @(negedge clk) begin
    if (rv1) begin q1d.push_back(rdata1); q1c.push_back(cyc); end
    if (rv2) begin q2d.push_back(rdata2); q2c.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a command and hold it until accepted; acc is the accept cycle.
  task automatic issue(input bit s, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, output int acc);
    int n;
    @(negedge clk);
    sel = s; rd = r; wr = w; addr = a; wdata = d; be = b;
    n = 0;
    while ((s ? wr2 : wr1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: addr %h still waiting after %0d cycles", a, n);
    end
    acc = cyc;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic pop_rv(input bit s, input string tag, input logic [31:0] exp_d, input int exp_c);
    logic [31:0] d;
    int c;
    if ((s ? q2d.size() : q1d.size()) == 0) begin
      n_checks++; n_err++;
      $display("FAIL %s: got no readdatavalid, expected data %h at cycle %0d", tag, exp_d, exp_c);
    end else begin
      if (s) begin d = q2d.pop_front(); c = q2c.pop_front(); end
      else   begin d = q1d.pop_front(); c = q1c.pop_front(); end
      check({tag, "_data"}, d, exp_d);
      check({tag, "_cyc"}, 32'(c), 32'(exp_c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    int acc[6];
    logic [31:0] exp_d;

    rst_n = 1'b0; addr = '0; wdata = '0; be = '0; rd = 1'b0; wr = 1'b0; sel = 1'b0;
    force_wait = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rv1", 32'(rv1), 32'd0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_wait1", 32'(wr1), 32'd0);
    check("rst_rv2", 32'(rv2), 32'd0);
    check("rst_err2", 32'(err2), 32'd0);
    rst_n = 1'b1;

    // Write then read back-to-back
    issue(0, 0, 1, 32'h10, 32'h12345678, 4'hF, a);
    issue(0, 1, 0, 32'h10, 32'h0, 4'h0, a);
    idle();
    repeat (4) @(negedge clk);
    pop_rv(0, "t1", 32'h12345678, a + 2);

    // Single byte-lane update
    issue(0, 0, 1, 32'h10, 32'h0000AB00, 4'b0010, a);
    issue(0, 1, 0, 32'h10, 32'h0, 4'h0, a);
    idle();
    repeat (4) @(negedge clk);
    pop_rv(0, "t2", 32'h1234AB78, a + 2);

    // Six back-to-back reads, no backpressure at default settings
    for (int i = 0; i < 6; i++) begin
      if (i != 4) issue(0, 0, 1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, a);
    end
    for (int i = 0; i < 6; i++) issue(0, 1, 0, 32'(4 * i), 32'h0, 4'h0, acc[i]);
    idle();
    repeat (6) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("t3_b2b", 32'(acc[i] - acc[0]), 32'(i));
      exp_d = (i == 4) ? 32'h1234AB78 : 32'hC0DE0000 + 32'(i);
      pop_rv(0, "t3_rd", exp_d, acc[i] + 2);
    end

    // force_wait holds a read off for three cycles
    @(negedge clk);
    force_wait = 1'b1; sel = 1'b0; rd = 1'b1; addr = 32'h10;
    #1 check("t4_wait_a", 32'(wr1), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("t4_wait_b", 32'(wr1), 32'd1);
    end
    @(negedge clk);
    force_wait = 1'b0;
    a = cyc;
    #1 check("t4_release", 32'(wr1), 32'd0);
    @(posedge clk);
    idle();
    repeat (4) @(negedge clk);
    check("t4_count", 32'(q1d.size()), 32'd1);
    pop_rv(0, "t4", 32'h1234AB78, a + 2);

    // Out-of-range read, clear, set-wins, last word, read+write together
    issue(0, 1, 0, 32'(4 * 1024), 32'h0, 4'h0, a);
    idle();
    check("t5_err_set", 32'(err1), 32'd1);
    repeat (3) @(negedge clk);
    pop_rv(0, "t5_oor", 32'h0, a + 2);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_err_clr", 32'(err1), 32'd0);
    err_clr = 1'b1;
    issue(0, 0, 1, 32'(4 * 1024), 32'hFFFFFFFF, 4'hF, a);
    idle();
    err_clr = 1'b0;
    check("t5_set_wins", 32'(err1), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_err_clr2", 32'(err1), 32'd0);
    issue(0, 0, 1, 32'hFFC, 32'hFACEFEED, 4'hF, a);
    issue(0, 1, 0, 32'hFFC, 32'h0, 4'h0, a);
    idle();
    check("t5_last_noerr", 32'(err1), 32'd0);
    repeat (3) @(negedge clk);
    pop_rv(0, "t5_last", 32'hFACEFEED, a + 2);
    issue(0, 1, 1, 32'h20, 32'h55AA55AA, 4'hF, a);
    idle();
    check("t5_rw_err", 32'(err1), 32'd1);
    repeat (4) @(negedge clk);
    check("t5_rw_novalid", 32'(q1d.size()), 32'd0);
    issue(0, 1, 0, 32'h20, 32'h0, 4'h0, a);
    idle();
    repeat (3) @(negedge clk);
    pop_rv(0, "t5_rw_data", 32'h55AA55AA, a + 2);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // dut2: latency 6 with only 4 reads allowed in flight
    for (int i = 0; i < 6; i++) begin
      exp_d = (i == 4) ? 32'hDEADBEEF : 32'hB0000000 + 32'(i);
      issue(1, 0, 1, 32'(4 * i), exp_d, 4'hF, a);
    end
    for (int i = 0; i < 6; i++) issue(1, 1, 0, 32'(4 * i), 32'h0, 4'h0, acc[i]);
    idle();
    repeat (14) @(negedge clk);
    check("t3b_acc3", 32'(acc[3] - acc[0]), 32'd3);
    check("t3b_acc4", 32'(acc[4] - acc[0]), 32'd6);
    check("t3b_acc5", 32'(acc[5] - acc[0]), 32'd7);
    for (int i = 0; i < 6; i++) begin
      exp_d = (i == 4) ? 32'hDEADBEEF : 32'hB0000000 + 32'(i);
      pop_rv(1, "t3b_rd", exp_d, acc[i] + 6);
    end

    // Reset with two reads in flight on dut2
    issue(1, 1, 0, 32'h10, 32'h0, 4'h0, a);
    issue(1, 1, 0, 32'h0, 32'h0, 4'h0, a);
    @(negedge clk);
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_wait", 32'(wr2), 32'd0);
    check("t6_err", 32'(err2), 32'd0);
    repeat (10) @(negedge clk);
    check("t6_novalid2", 32'(q2d.size()), 32'd0);
    check("t6_novalid1", 32'(q1d.size()), 32'd0);
    for (int i = 0; i < 4; i++) issue(1, 1, 0, 32'h10, 32'h0, 4'h0, acc[i]);
    idle();
    check("t6_pend_restart", 32'(acc[3] - acc[0]), 32'd3);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) pop_rv(1, "t6_rd2", 32'hDEADBEEF, acc[i] + 6);
    issue(0, 1, 0, 32'h10, 32'h0, 4'h0, b);
    idle();
    repeat (3) @(negedge clk);
    pop_rv(0, "t6_rd1", 32'h1234AB78, b + 2);

    repeat (8) @(negedge clk);
    check("end_extra1", 32'(q1d.size()), 32'd0);
    check("end_extra2", 32'(q2d.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
